// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface bundling the hazard controller's pipeline-side signals.
// master: the pipeline datapath (drives status, receives latch controls).
// slave:  the hazard controller itself.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    // Status from the pipeline
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_dREN;
    logic [REG_W-1:0] ex_wsel;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_redirect;
    logic             ex_halt;
    logic             wb_halt;

    // Controls back to the pipeline
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    // Debug view of the controller state: 0 RUN, 1 DWAIT, 2 DRAIN, 3 HALTED
    logic [1:0]       fsm_state;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               ex_redirect, ex_halt, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, stall_cycles, flush_count, fsm_state
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
               ex_redirect, ex_halt, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               halted, stall_cycles, flush_count, fsm_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: decides per cycle which
// pipeline latches advance or take a bubble and whether the PC updates.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter outputs are tied to zero.
// Handshake: each control is a same-cycle qualifier; a latch samples its
// input on CLK only when its enable is 1, and loads a bubble instead when
// its flush is also 1 (a flush without its enable has no meaning and never
// occurs).
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t fsm_q, fsm_d;
    logic   halted_q, halted_d;

    logic [REG_W-1:0] ex_wsel, id_rs, id_rt;
    logic mem_busy, load_use;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;

    assign ex_wsel = hz.ex_wsel;
    assign id_rs   = hz.id_rs;
    assign id_rt   = hz.id_rt;

    // Hazard terms: outstanding dcache access and load-use dependency
    always_comb begin
        mem_busy = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
        load_use = hz.ex_dREN & (ex_wsel != '0) &
                   ((ex_wsel == id_rs) | (ex_wsel == id_rt));
    end

    // Next state and per-cycle latch/PC control decision
    always_comb begin
        fsm_d      = fsm_q;
        halted_d   = halted_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (fsm_q)
            RUN, DWAIT: begin
                if (mem_busy) begin
                    // Whole pipeline frozen until the dcache answers
                    fsm_d = DWAIT;
                end else begin
                    fsm_d    = hz.ex_halt ? DRAIN : RUN;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    if (hz.ex_redirect) begin
                        // Squash the two younger wrong-path instructions
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use || !hz.ihit) begin
                        // Hold fetch/decode, insert a bubble into EX
                        idex_flush = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Stop fetching; older instructions flow out behind the halt
                if (!mem_busy) begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = load_use;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end
            end
            HALTED: begin
                fsm_d = HALTED;
            end
        endcase
        if (hz.wb_halt) begin
            fsm_d    = HALTED;
            halted_d = 1'b1;
        end
        if (!nRST) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    // State and sticky halt registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fsm_q    <= RUN;
            halted_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            halted_q <= halted_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Saturating performance counters, frozen once halted
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (fsm_q != HALTED) begin
            if (!pc_en && (stall_cycles_q != '1))
                stall_cycles_d = stall_cycles_q + CNT_ONE;
            if ((ifid_flush || idex_flush) && (flush_count_q != '1))
                flush_count_d = flush_count_q + CNT_ONE;
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_count  = {CNT_W{1'b0}};
`endif

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.idex_en    = idex_en;
    assign hz.exmem_en   = exmem_en;
    assign hz.memwb_en   = memwb_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.halted     = halted_q;
    assign hz.fsm_state  = fsm_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 32;
    localparam int S_RUN = 0, S_DWAIT = 1, S_DRAIN = 2, S_HALTED = 3;

    // Control vector order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_ALL   = 7'b1111100;
    localparam logic [6:0] C_BUBL  = 7'b0011101;
    localparam logic [6:0] C_REDIR = 7'b1111111;
    localparam logic [6:0] C_DRAIN = 7'b0111110;

    logic CLK = 1'b0;
    logic nRST;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz();

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hz.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int               m_state  = S_RUN;
    logic             m_halted = 1'b0;
    logic [CNT_W-1:0] m_stall  = '0;
    logic [CNT_W-1:0] m_flush  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush};
    endfunction

    // What each latch and the PC must do this cycle, from the hazard rules
    function automatic logic [6:0] model_ctrl(input int st);
        logic busy, lu, pc, ifid_adv, ifid_bub, idex_bub;
        busy = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
        lu   = hz.ex_dREN && (hz.ex_wsel != 0) &&
               (hz.ex_wsel == hz.id_rs || hz.ex_wsel == hz.id_rt);
        if (!nRST || st == S_HALTED || busy) return C_NONE;
        // Back end always moves once memory is not stalling
        if (st == S_DRAIN) begin
            pc = 0; ifid_adv = 1; ifid_bub = 1; idex_bub = lu;
        end else if (hz.ex_redirect) begin
            pc = 1; ifid_adv = 1; ifid_bub = 1; idex_bub = 1;
        end else if (lu || !hz.ihit) begin
            pc = 0; ifid_adv = 0; ifid_bub = 0; idex_bub = 1;
        end else begin
            pc = 1; ifid_adv = 1; ifid_bub = 0; idex_bub = 0;
        end
        return {pc, ifid_adv, 1'b1, 1'b1, 1'b1, ifid_bub, idex_bub};
    endfunction

    // Model state advance on each clock
    always @(posedge CLK or negedge nRST) begin
        logic [6:0] e;
        logic busy;
        if (!nRST) begin
            m_state = S_RUN; m_halted = 0; m_stall = '0; m_flush = '0;
        end else begin
            e    = model_ctrl(m_state);
            busy = (hz.mem_dREN || hz.mem_dWEN) && !hz.dhit;
`ifdef PIPE_PERF_CNT_EN
            if (m_state != S_HALTED) begin
                if (!e[6] && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1;
                if ((e[1] || e[0]) && m_flush != {CNT_W{1'b1}}) m_flush = m_flush + 1;
            end
`endif
            if (hz.wb_halt) begin
                m_state = S_HALTED; m_halted = 1;
            end else if (m_state == S_RUN || m_state == S_DWAIT) begin
                if (busy) m_state = S_DWAIT;
                else if (hz.ex_halt) m_state = S_DRAIN;
                else m_state = S_RUN;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge CLK) begin
        check("ctrl", {57'd0, dut_ctrl()}, {57'd0, model_ctrl(m_state)});
        check("halted", {63'd0, hz.halted}, {63'd0, m_halted});
        check("fsm", {62'd0, hz.fsm_state}, 64'(m_state));
        check("stall_cycles", {32'd0, hz.stall_cycles}, {32'd0, m_stall});
        check("flush_count", {32'd0, hz.flush_count}, {32'd0, m_flush});
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        hz.ihit = 1; hz.dhit = 0; hz.mem_dREN = 0; hz.mem_dWEN = 0;
        hz.ex_dREN = 0; hz.ex_wsel = 5'd7; hz.id_rs = 5'd1; hz.id_rt = 5'd2;
        hz.ex_redirect = 0; hz.ex_halt = 0; hz.wb_halt = 0;
    endtask

    initial begin
        nRST = 0;
        idle();
        #2;
        check("reset_ctrl", {57'd0, dut_ctrl()}, {57'd0, C_NONE});
        check("reset_halted", {63'd0, hz.halted}, 64'd0);
        check("reset_fsm", {62'd0, hz.fsm_state}, 64'd0);
        step(); step();
        nRST = 1;

        // Load-use stall, then release
        hz.ex_dREN = 1; hz.ex_wsel = 5'd5; hz.id_rs = 5'd5;
        #2 check("lu_stall", {57'd0, dut_ctrl()}, {57'd0, C_BUBL});
        step();
        hz.ex_dREN = 0;
        #2 check("lu_release", {57'd0, dut_ctrl()}, {57'd0, C_ALL});
        step();

        // Three-cycle dcache miss
        idle();
        hz.mem_dREN = 1; hz.dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #2 check("dmiss_frozen", {57'd0, dut_ctrl()}, {57'd0, C_NONE});
            if (i > 0) check("dmiss_dwait", {62'd0, hz.fsm_state}, 64'(S_DWAIT));
            step();
        end
        hz.dhit = 1;
        #2 check("dmiss_done", {57'd0, dut_ctrl()}, {57'd0, C_ALL});
        step();
        #2 check("dmiss_run", {62'd0, hz.fsm_state}, 64'(S_RUN));
        idle();

        // Redirect without ihit, then with a pending dcache miss
        hz.ex_redirect = 1; hz.ihit = 0;
        #2 check("redir_noihit", {57'd0, dut_ctrl()}, {57'd0, C_REDIR});
        hz.mem_dREN = 1;
        #1 check("redir_busy", {57'd0, dut_ctrl()}, {57'd0, C_NONE});
        step();
        idle();
        step();

        // Register zero never creates a load-use hazard; redirect beats load-use
        hz.ex_dREN = 1; hz.ex_wsel = 5'd0; hz.id_rs = 5'd0;
        #2 check("lu_r0", {57'd0, dut_ctrl()}, {57'd0, C_ALL});
        hz.ex_wsel = 5'd5; hz.id_rt = 5'd5; hz.ex_redirect = 1;
        #1 check("lu_redir", {57'd0, dut_ctrl()}, {57'd0, C_REDIR});
        step();
        idle();

        // Counters: fresh reset, 2-cycle miss, one redirect
        nRST = 0;
        step();
        nRST = 1;
        hz.mem_dREN = 1;
        step(); step();
        hz.dhit = 1;
        step();
        idle();
        hz.ex_redirect = 1;
        step();
        idle();
`ifdef PIPE_PERF_CNT_EN
        #2 check("cnt_stall", {32'd0, hz.stall_cycles}, 64'd2);
        check("cnt_flush", {32'd0, hz.flush_count}, 64'd1);
`else
        #2 check("cnt_stall", {32'd0, hz.stall_cycles}, 64'd0);
        check("cnt_flush", {32'd0, hz.flush_count}, 64'd0);
`endif
        step();

        // Halt drain and sticky halted
        hz.ex_halt = 1;
        step();
        hz.ex_halt = 0;
        #2 check("drain1", {57'd0, dut_ctrl()}, {57'd0, C_DRAIN});
        check("drain1_fsm", {62'd0, hz.fsm_state}, 64'(S_DRAIN));
        step();
        hz.wb_halt = 1; hz.ex_redirect = 1;
        #2 check("drain2", {57'd0, dut_ctrl()}, {57'd0, C_DRAIN});
        step();
        hz.wb_halt = 0;
        #2 check("halted_set", {63'd0, hz.halted}, 64'd1);
        check("halted_ctrl", {57'd0, dut_ctrl()}, {57'd0, C_NONE});
        step(); step();
        check("halted_hold", {63'd0, hz.halted}, 64'd1);
        nRST = 0;
        #1 check("halted_clear", {63'd0, hz.halted}, 64'd0);
        step();
        nRST = 1;
        idle();
        #1 check("after_reset_fsm", {62'd0, hz.fsm_state}, 64'(S_RUN));
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            nRST = !((m_state == S_HALTED && $urandom_range(0, 3) == 0) ||
                     $urandom_range(0, 299) == 0);
            hz.ihit        = ($urandom_range(0, 3) != 0);
            hz.dhit        = ($urandom_range(0, 1) == 1);
            hz.mem_dREN    = ($urandom_range(0, 3) == 0);
            hz.mem_dWEN    = ($urandom_range(0, 5) == 0);
            hz.ex_dREN     = ($urandom_range(0, 1) == 1);
            hz.ex_wsel     = REG_W'($urandom_range(0, 3));
            hz.id_rs       = REG_W'($urandom_range(0, 3));
            hz.id_rt       = REG_W'($urandom_range(0, 3));
            hz.ex_redirect = ($urandom_range(0, 5) == 0);
            hz.ex_halt     = ($urandom_range(0, 39) == 0);
            hz.wb_halt     = ($urandom_range(0, 59) == 0);
            step();
        end

        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
